hazard_stall_ctrl: RTL and testbench

- Pipeline controller that sequences the decode stage of the 5-stage MIPS core.
- Decides each cycle whether the PC and IF/ID register advance, whether a bubble is injected into ID/EX, and whether IF/ID is flushed.
- Covers three cases: load-use hazards, taken-branch flushes, and a multi-cycle multiply/divide unit (HI/LO reads stall until the result is ready).
- Sits beside DECODE and drives the pipeline-register enables.

---
 rtl/hazard_stall_ctrl.sv | 103 ++++++++++
 tb/tb_hazard_stall_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Decode-stage hazard controller: load-use, branch flush and mult/div
// HI/LO interlock, with a saturating stall-cycle counter.
module hazard_stall_ctrl #(
    parameter int MD_CYCLES = 32,
    parameter int CNT_W     = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             id_valid,
    input  logic [5:0]       id_opcode,
    input  logic [5:0]       id_funcode,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_branch_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_count
);

    // The issue cycle itself counts as the first unit cycle, so the HI/LO
    // read released exactly MD_CYCLES cycles after MULT entered decode.
    localparam logic [5:0] MD_LOAD = 6'(MD_CYCLES - 1);

    logic [5:0]       md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic rtype;
    logic md_issue;
    logic hilo_read;
    logic load_use;
    logic busy;
    logic hilo_stall;
    logic stall;
    logic md_accept;

    assign rtype     = id_valid && (id_opcode == 6'h00);
    assign md_issue  = rtype && (id_funcode inside {6'h18, 6'h19, 6'h1A, 6'h1B});
    assign hilo_read = rtype && (id_funcode inside {6'h10, 6'h12});
    assign load_use  = id_valid && ex_mem_read && (ex_rd != 5'd0) &&
                       ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

    assign busy       = (md_cnt_q != 6'd0);
    assign hilo_stall = hilo_read && busy;
    assign stall      = !ex_branch_taken && (hilo_stall || load_use);
    assign md_accept  = md_issue && !ex_branch_taken && !stall;

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        md_busy     = busy;
        if (!reset_n) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            md_busy     = 1'b0;
        end else if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (stall) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    always_comb begin
        md_cnt_d = md_cnt_q;
        if (md_accept) begin
            md_cnt_d = MD_LOAD;
        end else if (busy) begin
            md_cnt_d = md_cnt_q - 6'd1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            md_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed-vector bench for hazard_stall_ctrl; a second CNT_W=4 instance
// shares the stimulus to exercise counter saturation.
module tb_hazard_stall_ctrl;

    logic        clock;
    logic        reset_n;
    logic        id_valid;
    logic [5:0]  id_opcode;
    logic [5:0]  id_funcode;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic        ex_mem_read;
    logic [4:0]  ex_rd;
    logic        ex_branch_taken;

    logic        pc_write, ifid_write, ifid_flush, idex_bubble, md_busy;
    logic [15:0] stall_count;
    logic        pc_write4, ifid_write4, ifid_flush4, idex_bubble4, md_busy4;
    logic [3:0]  stall_count4;

    int n_cmp = 0;
    int n_err = 0;

    hazard_stall_ctrl #(.MD_CYCLES(32), .CNT_W(16)) dut (
        .clock(clock), .reset_n(reset_n), .id_valid(id_valid),
        .id_opcode(id_opcode), .id_funcode(id_funcode), .id_rs(id_rs),
        .id_rt(id_rt), .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
        .pc_write(pc_write), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .md_busy(md_busy), .stall_count(stall_count)
    );

    hazard_stall_ctrl #(.MD_CYCLES(32), .CNT_W(4)) dut4 (
        .clock(clock), .reset_n(reset_n), .id_valid(id_valid),
        .id_opcode(id_opcode), .id_funcode(id_funcode), .id_rs(id_rs),
        .id_rt(id_rt), .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
        .pc_write(pc_write4), .ifid_write(ifid_write4),
        .ifid_flush(ifid_flush4), .idex_bubble(idex_bubble4),
        .md_busy(md_busy4), .stall_count(stall_count4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [3:0] en;
    assign en = {pc_write, ifid_write, ifid_flush, idex_bubble};

    task automatic idle_inputs();
        id_valid = 1'b0; id_opcode = 6'h00; id_funcode = 6'h00;
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
        ex_mem_read = 1'b0; ex_rd = 5'd0; ex_branch_taken = 1'b0;
    endtask

    task automatic set_rtype(input logic [5:0] fn);
        id_valid = 1'b1; id_opcode = 6'h00; id_funcode = fn;
        id_rs = 5'd1; id_rt = 5'd2; id_uses_rt = 1'b1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        #2 reset_n = 1'b0;
        #3 reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        set_rtype(6'h18);
        tick();
        set_rtype(6'h20);
        for (int i = 0; i < 11; i++) tick();
        n_cmp++;
        if (md_busy !== 1'b1) begin
            n_err++; $display("FAIL rst_busy_pre: got %b want 1", md_busy);
        end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({en, md_busy} !== 5'b00110) begin
            n_err++; $display("FAIL rst_outputs: got %b want 00110", {en, md_busy});
        end
        #2 reset_n = 1'b1;
        idle_inputs();
        #1;
        n_cmp++;
        if ({en, md_busy} !== 5'b11000) begin
            n_err++; $display("FAIL rst_release: got %b want 11000", {en, md_busy});
        end
        n_cmp++;
        if (stall_count !== 16'd0) begin
            n_err++; $display("FAIL rst_count: got %0d want 0", stall_count);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        id_valid = 1'b1; id_opcode = 6'h08; id_rs = 5'd8; id_rt = 5'd3;
        id_uses_rt = 1'b0; ex_mem_read = 1'b1; ex_rd = 5'd8;
        #1;
        n_cmp++;
        if (en !== 4'b0001) begin
            n_err++; $display("FAIL lu_stall: got %b want 0001", en);
        end
        tick();
        ex_mem_read = 1'b0; ex_rd = 5'd12;
        #1;
        n_cmp++;
        if (en !== 4'b1100 || stall_count !== 16'd1) begin
            n_err++;
            $display("FAIL lu_release: en %b cnt %0d want 1100 cnt 1", en, stall_count);
        end
        id_rs = 5'd0; ex_mem_read = 1'b1; ex_rd = 5'd0;
        #1;
        n_cmp++;
        if (en !== 4'b1100) begin
            n_err++; $display("FAIL lu_r0: got %b want 1100", en);
        end
        tick();
        n_cmp++;
        if (stall_count !== 16'd1) begin
            n_err++; $display("FAIL lu_r0_cnt: got %0d want 1", stall_count);
        end
    endtask

    task automatic test_rt_sense();
        do_reset();
        id_valid = 1'b1; id_opcode = 6'h00; id_funcode = 6'h20;
        id_rs = 5'd3; id_rt = 5'd9; id_uses_rt = 1'b0;
        ex_mem_read = 1'b1; ex_rd = 5'd9;
        #1;
        n_cmp++;
        if (en !== 4'b1100) begin
            n_err++; $display("FAIL rt_unused: got %b want 1100", en);
        end
        id_uses_rt = 1'b1;
        #1;
        n_cmp++;
        if (en !== 4'b0001) begin
            n_err++; $display("FAIL rt_used: got %b want 0001", en);
        end
        tick();
        ex_mem_read = 1'b0;
        #1;
        n_cmp++;
        if (en !== 4'b1100 || stall_count !== 16'd1) begin
            n_err++;
            $display("FAIL rt_release: en %b cnt %0d want 1100 cnt 1", en, stall_count);
        end
    endtask

    task automatic test_mult_mflo();
        int bad;
        do_reset();
        set_rtype(6'h18);
        #1;
        n_cmp++;
        if ({en, md_busy} !== 5'b11000) begin
            n_err++; $display("FAIL md_issue: got %b want 11000", {en, md_busy});
        end
        tick();
        set_rtype(6'h12);
        bad = 0;
        for (int k = 1; k <= 31; k++) begin
            #1;
            if (en !== 4'b0001 || md_busy !== 1'b1) bad++;
            tick();
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++; $display("FAIL md_hold: %0d bad cycles want 0", bad);
        end
        n_cmp++;
        if ({en, md_busy} !== 5'b11000) begin
            n_err++; $display("FAIL md_release: got %b want 11000", {en, md_busy});
        end
        n_cmp++;
        if (stall_count !== 16'd31) begin
            n_err++; $display("FAIL md_count: got %0d want 31", stall_count);
        end
        n_cmp++;
        if (stall_count4 !== 4'd15) begin
            n_err++; $display("FAIL md_count4: got %0d want 15", stall_count4);
        end
    endtask

    task automatic test_branch_priority();
        do_reset();
        set_rtype(6'h18);
        tick();
        set_rtype(6'h10);
        #1;
        n_cmp++;
        if (en !== 4'b0001) begin
            n_err++; $display("FAIL br_mfhi_stall: got %b want 0001", en);
        end
        tick();
        ex_branch_taken = 1'b1;
        #1;
        n_cmp++;
        if (en !== 4'b1111 || md_busy !== 1'b1) begin
            n_err++;
            $display("FAIL br_flush: en %b busy %b want 1111 busy 1", en, md_busy);
        end
        tick();
        n_cmp++;
        if (stall_count !== 16'd1) begin
            n_err++; $display("FAIL br_nocount: got %0d want 1", stall_count);
        end
        do_reset();
        set_rtype(6'h1A);
        ex_branch_taken = 1'b1;
        tick();
        idle_inputs();
        #1;
        n_cmp++;
        if (md_busy !== 1'b0) begin
            n_err++; $display("FAIL br_squash: got %b want 0", md_busy);
        end
        set_rtype(6'h1B);
        tick();
        set_rtype(6'h12);
        id_valid = 1'b0;
        #1;
        n_cmp++;
        if (en !== 4'b1100 || md_busy !== 1'b1) begin
            n_err++;
            $display("FAIL br_invalid: en %b busy %b want 1100 busy 1", en, md_busy);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        id_valid = 1'b1; id_opcode = 6'h23; id_rs = 5'd5;
        ex_mem_read = 1'b1; ex_rd = 5'd5;
        for (int i = 0; i < 20; i++) tick();
        idle_inputs();
        #1;
        n_cmp++;
        if (stall_count4 !== 4'd15) begin
            n_err++; $display("FAIL sat_cnt4: got %0d want 15", stall_count4);
        end
        n_cmp++;
        if (stall_count !== 16'd20) begin
            n_err++; $display("FAIL sat_cnt16: got %0d want 20", stall_count);
        end
    endtask

    task automatic test_back_to_back();
        int stalls;
        do_reset();
        set_rtype(6'h19);
        tick();
        set_rtype(6'h20);
        for (int i = 0; i < 10; i++) tick();
        set_rtype(6'h18);
        tick();
        set_rtype(6'h12);
        stalls = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (!pc_write) stalls++;
            tick();
        end
        n_cmp++;
        if (stalls != 31) begin
            n_err++; $display("FAIL b2b_restart: got %0d stalls want 31", stalls);
        end
    endtask

    initial begin
        reset_n = 1'b1;
        idle_inputs();
        test_reset();
        test_load_use();
        test_rt_sense();
        test_mult_mflo();
        test_branch_priority();
        test_saturation();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
